// File: rtl/mem_pkg.sv
// Shared types and limits for the multi-channel memory slave.
// Response bundle carries data at the widest supported width.
package mem_pkg;

   localparam int RD_LATENCY_MIN = 1;
   localparam int RD_LATENCY_MAX = 4;
   localparam int NUM_CH_MAX     = 4;
   localparam int MEM_DATA_W     = 64;

   typedef struct packed {
      logic                  valid;
      logic                  err;
      logic [MEM_DATA_W-1:0] data;
   } mem_rsp_t;

   function automatic int bytes_of(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Per-channel response delay line, RD_LATENCY stages deep.
// Reset wipes every stage so in-flight responses never emerge.
module mem_rsp_pipe
   import mem_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic     clk,
   input  logic     reset,
   input  mem_rsp_t rsp_in,
   output mem_rsp_t rsp_out
);

   mem_rsp_t st [RD_LATENCY];

   // shift responses toward the output, clearing all on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RD_LATENCY; i++)
            st[i] <= '0;
      end else begin
         st[0] <= rsp_in;
         for (int i = 1; i < RD_LATENCY; i++)
            st[i] <= st[i-1];
      end
   end

   assign rsp_out = st[RD_LATENCY-1];

endmodule

// File: rtl/mem_slave_mp.sv
// Multi-channel memory slave: shared word array, byte strobes,
// lowest-channel-wins write merge and fixed-latency responses.
module mem_slave_mp
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE   = 16,
   parameter int NUM_CH     = 2,
   parameter int RD_LATENCY = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_CH-1:0]                    wr,
   input  logic [NUM_CH-1:0]                    rd,
   input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    addr,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    wdata,
   input  logic [NUM_CH-1:0][DATA_WIDTH/8-1:0]  wstrb,
   output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    rdata,
   output logic [NUM_CH-1:0]                    slv_rsp,
   output logic [NUM_CH-1:0]                    err
);

   localparam int NB = bytes_of(DATA_WIDTH);
   localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(MEM_SIZE);

   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

   logic [NUM_CH-1:0]         bad;
   logic [NUM_CH-1:0]         wr_ok;
   logic [NUM_CH-1:0]         rd_ok;
   logic [NUM_CH-1:0][AW-1:0] idx;

   mem_rsp_t rsp_in  [NUM_CH];
   mem_rsp_t rsp_out [NUM_CH];

   // decode each channel and build the response entering its pipe
   always_comb begin
      bad   = '0;
      wr_ok = '0;
      rd_ok = '0;
      idx   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         rsp_in[c] = '0;
         idx[c]    = addr[c][AW-1:0];
         bad[c]    = (wr[c] & rd[c]) | ({1'b0, addr[c]} >= LIM);
         wr_ok[c]  = wr[c] & ~bad[c];
         rd_ok[c]  = rd[c] & ~bad[c];
         rsp_in[c].valid = wr[c] | rd[c];
         rsp_in[c].err   = (wr[c] | rd[c]) & bad[c];
         if (rd_ok[c])
            rsp_in[c].data = MEM_DATA_W'(mem[idx[c]]);
      end
   end

   // byte-lane write; descending loop lets lower channels win
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < MEM_SIZE; w++)
            mem[w] <= '0;
      end else begin
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (wr_ok[c]) begin
               for (int b = 0; b < NB; b++) begin
                  if (wstrb[c][b])
                     mem[idx[c]][8*b +: 8] <= wdata[c][8*b +: 8];
               end
            end
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mem_rsp_pipe #(
         .RD_LATENCY (RD_LATENCY)
      ) u_pipe (
         .clk     (clk),
         .reset   (reset),
         .rsp_in  (rsp_in[c]),
         .rsp_out (rsp_out[c])
      );

      assign slv_rsp[c] = rsp_out[c].valid;
      assign err[c]     = rsp_out[c].err;
      assign rdata[c]   = rsp_out[c].data[DATA_WIDTH-1:0];

      if (DATA_WIDTH < MEM_DATA_W) begin : g_pad
         logic pad_unused;
         assign pad_unused = ^rsp_out[c].data[MEM_DATA_W-1:DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_mem_slave_mp.sv
// Directed bench for mem_slave_mp at latency 1 and latency 3.
// Inputs change after negedge; outputs are checked at negedge.
module tb_mem_slave_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [1:0]        wr, rd;
   logic [1:0][7:0]   addr;
   logic [1:0][31:0]  wdata;
   logic [1:0][3:0]   wstrb;
   logic [1:0][31:0]  rdata;
   logic [1:0]        slv_rsp, err;

   logic              b_reset;
   logic [1:0]        b_wr, b_rd;
   logic [1:0][7:0]   b_addr;
   logic [1:0][31:0]  b_wdata;
   logic [1:0][3:0]   b_wstrb;
   logic [1:0][31:0]  b_rdata;
   logic [1:0]        b_slv_rsp, b_err;

   int errors = 0;
   int checks = 0;

   mem_slave_mp u_dut (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .rd      (rd),
      .addr    (addr),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .rdata   (rdata),
      .slv_rsp (slv_rsp),
      .err     (err)
   );

   mem_slave_mp #(.RD_LATENCY(3)) u_lat3 (
      .clk     (clk),
      .reset   (b_reset),
      .wr      (b_wr),
      .rd      (b_rd),
      .addr    (b_addr),
      .wdata   (b_wdata),
      .wstrb   (b_wstrb),
      .rdata   (b_rdata),
      .slv_rsp (b_slv_rsp),
      .err     (b_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wr = '0; rd = '0; addr = '0; wdata = '0; wstrb = '0;
      b_wr = '0; b_rd = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
   endtask

   task automatic req(input int ch, input logic w, input logic r,
                      input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s);
      wr[ch] = w; rd[ch] = r; addr[ch] = a;
      wdata[ch] = d; wstrb[ch] = s;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      idle();
      reset = 1'b0;
      b_reset = 1'b0;
      step(); step();
      chk("rst_rsp", 64'(slv_rsp), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_rdata", 64'(rdata), 64'h0);
      chk("rst_b_rsp", 64'(b_slv_rsp), 64'h0);
      reset = 1'b1;
      b_reset = 1'b1;

      // full write then read back
      step();
      req(0, 1, 0, 8'd3, 32'hDEADBEEF, 4'hF);
      step();
      chk("wr3_rsp", 64'(slv_rsp), 64'h1);
      chk("wr3_err", 64'(err), 64'h0);
      idle();
      req(0, 0, 1, 8'd3, 32'h0, 4'h0);
      step();
      chk("rd3_rsp", 64'(slv_rsp), 64'h1);
      chk("rd3_data", 64'(rdata[0]), 64'hDEADBEEF);
      chk("rd3_err", 64'(err), 64'h0);
      idle();
      step();
      chk("idle_rsp", 64'(slv_rsp), 64'h0);
      chk("idle_rdata", 64'(rdata), 64'h0);

      // partial strobe write
      req(0, 1, 0, 8'd5, 32'h11223344, 4'hF);
      step();
      req(0, 1, 0, 8'd5, 32'hAABBCCDD, 4'h5);
      step();
      chk("wr5p_rsp", 64'(slv_rsp), 64'h1);
      req(0, 0, 1, 8'd5, 32'h0, 4'h0);
      step();
      chk("rd5_data", 64'(rdata[0]), 64'h11BB33DD);

      // same-cycle writers, per-byte priority
      idle();
      req(0, 1, 0, 8'd2, 32'h000000AA, 4'h1);
      req(1, 1, 0, 8'd2, 32'h0000BBCC, 4'h3);
      step();
      chk("ww2_rsp", 64'(slv_rsp), 64'h3);
      chk("ww2_err", 64'(err), 64'h0);
      idle();
      req(0, 0, 1, 8'd2, 32'h0, 4'h0);
      step();
      chk("rd2_data", 64'(rdata[0]), 64'h0000BBAA);

      // error requests leave storage untouched
      idle();
      req(0, 1, 0, 8'd0, 32'h12345678, 4'hF);
      step();
      idle();
      req(0, 1, 1, 8'd0, 32'hFFFFFFFF, 4'hF);
      req(1, 0, 1, 8'd16, 32'h0, 4'h0);
      step();
      chk("err_rsp", 64'(slv_rsp), 64'h3);
      chk("err_err", 64'(err), 64'h3);
      chk("err_rdata", 64'(rdata), 64'h0);
      idle();
      req(0, 0, 1, 8'd0, 32'h0, 4'h0);
      step();
      chk("rd0_data", 64'(rdata[0]), 64'h12345678);
      chk("rd0_err", 64'(err), 64'h0);

      // read-before-write collision
      idle();
      req(0, 1, 0, 8'd7, 32'h5, 4'hF);
      step();
      idle();
      req(0, 1, 0, 8'd7, 32'h9, 4'hF);
      req(1, 0, 1, 8'd7, 32'h0, 4'h0);
      step();
      chk("col_rsp", 64'(slv_rsp), 64'h3);
      chk("col_old", 64'(rdata[1]), 64'h5);
      idle();
      req(1, 0, 1, 8'd7, 32'h0, 4'h0);
      step();
      chk("col_new", 64'(rdata[1]), 64'h9);
      idle();

      // latency 3: write response timing
      b_wr[0] = 1'b1; b_addr[0] = 8'd0;
      b_wdata[0] = 32'hCAFE0001; b_wstrb[0] = 4'hF;
      step();
      idle();
      chk("l3_w_e0", 64'(b_slv_rsp), 64'h0);
      step();
      chk("l3_w_e1", 64'(b_slv_rsp), 64'h0);
      step();
      chk("l3_w_e2", 64'(b_slv_rsp), 64'h1);
      step();
      chk("l3_w_e3", 64'(b_slv_rsp), 64'h0);

      // latency 3: reads cut off by reset mid-pipeline
      b_rd[0] = 1'b1; b_addr[0] = 8'd0;
      step();
      b_addr[0] = 8'd1;
      step();
      b_addr[0] = 8'd2;
      b_reset = 1'b0;
      #1;
      chk("l3_rst_now", 64'(b_slv_rsp), 64'h0);
      step();
      chk("l3_rst_c1", 64'(b_slv_rsp), 64'h0);
      idle();
      step();
      chk("l3_rst_c2", 64'(b_slv_rsp), 64'h0);
      b_reset = 1'b1;
      step();
      chk("l3_post_c1", 64'(b_slv_rsp), 64'h0);
      step();
      chk("l3_post_c2", 64'(b_slv_rsp), 64'h0);
      step();
      chk("l3_post_c3", 64'(b_slv_rsp), 64'h0);

      // latency 3: storage cleared by reset
      b_rd[0] = 1'b1; b_addr[0] = 8'd0;
      step();
      idle();
      step();
      chk("l3_rd_e1", 64'(b_slv_rsp), 64'h0);
      step();
      chk("l3_rd_rsp", 64'(b_slv_rsp), 64'h1);
      chk("l3_rd_data", 64'(b_rdata[0]), 64'h0);
      chk("l3_rd_err", 64'(b_err), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_slave_mp.md
# mem_slave_mp

Parametrised multi-channel memory slave and the next-generation DUT behind the memory verification environment. It provides NUM_CH independent request channels into one shared storage array, with byte-lane write strobes, a configurable read latency and per-request error signalling. Every request receives exactly one in-order `slv_rsp` pulse, so the UVM monitors can score every transaction.

## Interface
- ADDR_WIDTH, 8, address bits per channel
- DATA_WIDTH, 32, data bits; must be a multiple of 8
- MEM_SIZE, 16, number of words; legal addresses are 0..MEM_SIZE-1
- NUM_CH, 2, number of request channels (1..4)
- RD_LATENCY, 1, cycles from the request-sampling edge to the response (1..4)

Ports:
- clk  in  1  single clock, posedge
- reset  in  1  asynchronous, active-low
- wr  in  [NUM_CH]  write request per channel
- rd  in  [NUM_CH]  read request per channel
- addr  in  [NUM_CH][ADDR_WIDTH]  word address
- wdata  in  [NUM_CH][DATA_WIDTH]  write data
- wstrb  in  [NUM_CH][DATA_WIDTH/8]  byte-lane enables; bit i covers wdata[8i+7:8i]
- rdata  out  [NUM_CH][DATA_WIDTH]  read data, valid only with slv_rsp on a read
- slv_rsp  out  [NUM_CH]  one-cycle response pulse per request
- err  out  [NUM_CH]  qualifies slv_rsp; high means the request was rejected

## Operation
- There is no backpressure. Each channel may issue one request per cycle; the request is sampled at posedge clk.
- Legal request: exactly one of wr/rd is high and addr < MEM_SIZE.
- Error request: wr and rd both high, or addr >= MEM_SIZE.
  - Storage is not touched.
  - The response carries err=1 and rdata=0.
- Write: at the sampling edge, store each byte whose wstrb bit is set; other bytes keep their value. wstrb=0 is legal and leaves the word unchanged.
- Read: capture the stored word at the sampling edge and return it after RD_LATENCY cycles.
- Same-cycle conflicts:
  - Two or more channels write the same address: resolved per byte; the lowest-index channel with that strobe bit set wins. All writers receive an OK response.
  - Read and write to the same address in the same cycle: the read returns the old data (read-before-write).
- A channel's responses come back strictly in request order. Responses are independent across channels.
- Reset (reset=0):
  - All storage words clear to 0.
  - slv_rsp, err and rdata clear to 0.
  - In-flight responses are discarded and never emitted, including when reset is asserted mid-pipeline.

## Timing
- Request sampled at edge N; slv_rsp, err and rdata are valid for exactly one cycle after edge N+RD_LATENCY-1. RD_LATENCY=1 means the response appears in the cycle following the request.
- Write and read responses use the same latency, so ordering is preserved.
- Full throughput: back-to-back requests on every channel every cycle; up to RD_LATENCY responses in flight per channel.
- A read issued at edge N+1 to an address written at edge N returns the new data.
- When slv_rsp=0: err=0 and rdata=0.
- After reset deasserts, the first request is accepted at the next posedge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `mem_pkg`:
  - RD_LATENCY_MIN/MAX and NUM_CH_MAX constants
  - `mem_rsp_t` struct {valid, err, data}
  - function `bytes_of(DATA_WIDTH)`
- Sub-module `mem_rsp_pipe`: per-channel shift register of RD_LATENCY `mem_rsp_t` stages with async active-low clear; instantiated NUM_CH times.
- The top level holds the storage array, request decode, byte-lane priority write and read capture.

## Test plan
- Reset, then ch0 writes 0xDEADBEEF to addr 3 with wstrb=0xF; ch0 reads addr 3 -> slv_rsp one cycle after each request, read rdata=0xDEADBEEF, err=0.
- Partial write: addr 5 holds 0x11223344; write 0xAABBCCDD with wstrb=0x5 -> read returns 0x11BB33DD.
- Same-cycle ch0 and ch1 writes to addr 2 (ch0 0x000000AA wstrb=0x1, ch1 0x0000BBCC wstrb=0x3) -> addr 2 = 0x0000BBAA, both slv_rsp with err=0.
- Errors: ch1 reads addr 16 (MEM_SIZE=16); ch0 drives wr=rd=1 at addr 0 -> slv_rsp with err=1, rdata=0; addr 0 contents unchanged.
- RD_LATENCY=3: reads to addrs 0,1,2 on consecutive cycles, then reset asserted two cycles after the first read -> no slv_rsp during or after reset; a subsequent read of addr 0 returns 0.
- Read/write collision: addr 7 holds 0x5; ch0 writes 0x9 to addr 7 while ch1 reads addr 7 in the same cycle -> ch1 rdata=0x5; a read in the next cycle returns 0x9.
